// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter and its prescaler.
package counter_pkg;

   localparam int CNT_WRAP = 0;
   localparam int CNT_SAT  = 1;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int clog2(input int unsigned n);
      int          bits_v;
      int unsigned reach_v;
      bits_v  = 0;
      reach_v = 32'd1;
      while (reach_v < n) begin
         reach_v = reach_v << 1;
         bits_v  = bits_v + 1;
      end
      if (bits_v < 1) begin
         bits_v = 1;
      end else begin
         bits_v = bits_v;
      end
      return bits_v;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: tick is high when the phase reaches PRESCALE-1.
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic tick
);

   localparam int             PW   = clog2(PRESCALE);
   localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase_r;

   // Phase advances on enabled cycles and wraps after LAST; restart forces it to 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_r <= '0;
      end else if (restart) begin
         phase_r <= '0;
      end else if (en) begin
         if (phase_r == LAST) begin
            phase_r <= '0;
         end else begin
            phase_r <= phase_r + PW'(1);
         end
      end else begin
         phase_r <= phase_r;
      end
   end

   assign tick = (phase_r == LAST);

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down modulus counter with load, clear, prescaler,
// wrap or saturate mode, terminal count, boundary pulse and sticky overflow.
module updown_counter
   import counter_pkg::*;
#(
   parameter int     WIDTH    = 4,
   parameter longint MODULUS  = 64'sd16,
   parameter int     SATURATE = 0,
   parameter int     PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             evt,
   output logic             ovf
);

   generate
      if (MODULUS < 64'sd2 || MODULUS > (64'sd1 << WIDTH)) begin : g_bad_modulus
         $error("updown_counter: MODULUS out of range for WIDTH");
      end
      if (PRESCALE < 1) begin : g_bad_prescale
         $error("updown_counter: PRESCALE must be at least 1");
      end
   endgenerate

   localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MODULUS - 64'sd1);
   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'sd1);
   localparam bit               SAT_MODE = (SATURATE == CNT_SAT);

   logic [WIDTH-1:0] out_r;
   logic             evt_r;
   logic             ovf_r;
   logic             tick_s;
   logic             step_s;
   logic             bnd_s;
   logic [WIDTH-1:0] next_out_s;
   logic [WIDTH:0]   inc_s;
   logic [WIDTH:0]   dec_s;
   logic [WIDTH:0]   ld_ext_s;

   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .restart (clr | load),
      .tick    (tick_s)
   );

   assign step_s   = en & tick_s;
   // One extra bit keeps MODULUS = 2^WIDTH from overflowing; its borrow marks the down boundary.
   assign inc_s    = {1'b0, out_r} + (WIDTH+1)'(1);
   assign dec_s    = {1'b0, out_r} - (WIDTH+1)'(1);
   assign ld_ext_s = {1'b0, load_val};

   // Next count and boundary detection with clr > load > step > hold priority.
   always_comb begin
      next_out_s = out_r;
      bnd_s      = 1'b0;
      if (clr) begin
         next_out_s = '0;
      end else if (load) begin
         if (ld_ext_s > MAX_EXT) begin
            next_out_s = MAX_VAL;
         end else begin
            next_out_s = load_val;
         end
      end else if (step_s) begin
         if (up) begin
            if (inc_s > MAX_EXT) begin
               bnd_s      = 1'b1;
               next_out_s = SAT_MODE ? MAX_VAL : '0;
            end else begin
               next_out_s = inc_s[WIDTH-1:0];
            end
         end else begin
            if (dec_s[WIDTH]) begin
               bnd_s      = 1'b1;
               next_out_s = SAT_MODE ? '0 : MAX_VAL;
            end else begin
               next_out_s = dec_s[WIDTH-1:0];
            end
         end
      end else begin
         next_out_s = out_r;
      end
   end

   // Count, event pulse and sticky overflow registers; a boundary beats ovf_clr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_r <= '0;
         evt_r <= 1'b0;
         ovf_r <= 1'b0;
      end else begin
         out_r <= next_out_s;
         evt_r <= bnd_s;
         ovf_r <= bnd_s | (ovf_r & ~ovf_clr);
      end
   end

   assign out = out_r;
   assign evt = evt_r;
   assign ovf = ovf_r;
   assign tc  = up ? (out_r == MAX_VAL) : (out_r == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: three counter configurations driven with shared random stimulus.
module tb_updown_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, up = 1'b1, load = 1'b0, clr = 1'b0, ovf_clr = 1'b0;
   logic [3:0] load_val = 4'd0;

   logic [2:0][3:0] dout;
   logic [2:0]      dtc, devt, dovf;

   typedef struct packed {
      logic [2:0][3:0] out;
      logic [2:0]      evt;
      logic [2:0]      ovf;
      logic [2:0]      tc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   int mods[3] = '{16, 10, 10};
   int sats[3] = '{0, 1, 0};
   int pss[3]  = '{1, 3, 2};
   int cnt[3]  = '{0, 0, 0};
   int ph[3]   = '{0, 0, 0};
   bit ov[3]   = '{1'b0, 1'b0, 1'b0};

   updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)) dut_a (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .clr(clr), .ovf_clr(ovf_clr), .out(dout[0]), .tc(dtc[0]), .evt(devt[0]), .ovf(dovf[0]));
   updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(3)) dut_b (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .clr(clr), .ovf_clr(ovf_clr), .out(dout[1]), .tc(dtc[1]), .evt(devt[1]), .ovf(dovf[1]));
   updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(2)) dut_c (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .clr(clr), .ovf_clr(ovf_clr), .out(dout[2]), .tc(dtc[2]), .evt(devt[2]), .ovf(dovf[2]));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, idx, $time, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model, queue the expectation.
   task automatic drive(input bit e, input bit u, input bit ld, input int lv,
                        input bit c, input bit oc, input bit rl);
      exp_t x;
      @(negedge clk);
      en = e; up = u; load = ld; load_val = 4'(lv); clr = c; ovf_clr = oc; rst = ~rl;
      for (int i = 0; i < 3; i++) begin
         bit bnd;
         bit tick;
         bnd  = 1'b0;
         tick = (ph[i] == pss[i] - 1);
         if (rl) begin
            cnt[i] = 0; ph[i] = 0; ov[i] = 1'b0;
         end else begin
            if (c) cnt[i] = 0;
            else if (ld) cnt[i] = (lv < mods[i]) ? lv : mods[i] - 1;
            else if (e && tick) begin
               if (u) begin
                  if ((cnt[i] + 1) % mods[i] == 0) begin
                     bnd = 1'b1; cnt[i] = sats[i] ? mods[i] - 1 : 0;
                  end else cnt[i] = cnt[i] + 1;
               end else begin
                  if (cnt[i] == 0) begin
                     bnd = 1'b1; cnt[i] = sats[i] ? 0 : mods[i] - 1;
                  end else cnt[i] = cnt[i] - 1;
               end
            end
            if (c || ld) ph[i] = 0;
            else if (e) ph[i] = (ph[i] + 1) % pss[i];
            ov[i] = bnd ? 1'b1 : (oc ? 1'b0 : ov[i]);
         end
         x.out[i] = 4'(cnt[i]);
         x.evt[i] = bnd;
         x.ovf[i] = ov[i];
         x.tc[i]  = u ? (cnt[i] == mods[i] - 1) : (cnt[i] == 0);
      end
      if (rl) begin
         #2;
         for (int i = 0; i < 3; i++) begin
            chk("async_rst_out", i, dout[i], 4'd0);
            chk("async_rst_evt", i, {3'd0, devt[i]}, 4'd0);
            chk("async_rst_ovf", i, {3'd0, dovf[i]}, 4'd0);
         end
      end
      q.push_back(x);
   endtask

   // Monitor: after each rising edge compare the DUT against the oldest expectation.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            x = q.pop_front();
            for (int i = 0; i < 3; i++) begin
               chk("out", i, dout[i], x.out[i]);
               chk("evt", i, {3'd0, devt[i]}, {3'd0, x.evt[i]});
               chk("ovf", i, {3'd0, dovf[i]}, {3'd0, x.ovf[i]});
               chk("tc", i, {3'd0, dtc[i]}, {3'd0, x.tc[i]});
            end
         end
      end
   end

   initial begin
      bit dir;
      dir = 1'b1;
      drive(0, 1, 0, 0, 0, 0, 1);
      repeat (20) drive(1, 1, 0, 0, 0, 0, 0);
      repeat (25) drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      drive(0, 1, 1, 8, 0, 0, 0);
      repeat (12) drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 1, 0);
      drive(0, 1, 1, 15, 0, 0, 0);
      drive(1, 1, 1, 3, 1, 0, 0);
      repeat (3) drive(1, 1, 0, 0, 0, 0, 0);
      repeat (2) drive(0, 1, 0, 0, 0, 0, 0);
      repeat (4) drive(1, 1, 0, 0, 0, 0, 0);
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(15) == 0) dir = ~dir;
         drive($urandom_range(9) < 8, dir, $urandom_range(19) == 0, $urandom_range(15),
               $urandom_range(31) == 0, $urandom_range(15) == 0, $urandom_range(199) == 0);
      end
      drive(0, 1, 1, 5, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 1);
      repeat (6) drive(1, 1, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("queue_drained", 0, 4'(q.size()), 4'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
